// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: PC sequencing, redirect selection, ROM addressing,
// IF/ID pipeline register and a sticky fetch-fault FSM.
module instr_fetch_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [31:0] RESET_PC   = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  branch_en,
  input  logic [31:0]           branch_target,
  input  logic                  jump_en,
  input  logic [25:0]           jump_addr,
  input  logic                  jr_en,
  input  logic [31:0]           jr_target,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic [31:0]           pc,
  output logic [DATA_WIDTH-1:0] if_id_instr,
  output logic [31:0]           if_id_pc_plus4,
  output logic                  if_id_valid,
  output logic                  fetch_fault
);

  // Byte size of the ROM window; 33 bits so large ADDR_WIDTH cannot overflow.
  localparam logic [32:0] ROM_BYTES = 33'(1) << (ADDR_WIDTH + 2);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [31:0]             r_pc;
  logic [31:0]             w_pc_nxt;
  logic [DATA_WIDTH-1:0]   r_if_instr;
  logic [DATA_WIDTH-1:0]   w_if_instr_nxt;
  logic [31:0]             r_if_pc_plus4;
  logic [31:0]             w_if_pc_plus4_nxt;
  logic                    r_if_valid;
  logic                    w_if_valid_nxt;
  logic                    r_fault;
  logic                    w_fault_nxt;

  logic [31:0]             w_offset;
  logic [31:0]             w_pc_plus4;
  logic [31:0]             w_jump_target;
  logic [31:0]             w_redirect_target;
  logic                    w_redirect;
  logic                    w_out_of_range;

  // Address decode and redirect target selection (jr > jump > branch).
  assign w_offset          = r_pc - RESET_PC;
  assign w_pc_plus4        = r_pc + 32'd4;
  assign w_jump_target     = {r_if_pc_plus4[31:28], jump_addr, 2'b00};
  assign w_redirect        = jr_en | jump_en | branch_en;
  assign w_redirect_target = jr_en   ? jr_target :
                             jump_en ? w_jump_target : branch_target;
  assign w_out_of_range    = (r_pc[1:0] != 2'b00) || ({1'b0, w_offset} >= ROM_BYTES);
  assign rom_addr          = w_offset[ADDR_WIDTH+1:2];

  // Next-state, next-PC and next IF/ID contents.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_if_instr_nxt    = r_if_instr;
    w_if_pc_plus4_nxt = r_if_pc_plus4;
    w_if_valid_nxt    = r_if_valid;
    w_fault_nxt       = r_fault;
    case (r_state)
      ST_RUN: begin
        if (w_redirect) begin
          w_pc_nxt = w_redirect_target;
        end else if (!w_out_of_range && !stall) begin
          w_pc_nxt = w_pc_plus4;
        end
        // An out-of-range fetch never enters IF/ID, even when rescued by a redirect.
        if (w_out_of_range || flush) begin
          w_if_instr_nxt    = '0;
          w_if_pc_plus4_nxt = '0;
          w_if_valid_nxt    = 1'b0;
        end else if (!stall) begin
          w_if_instr_nxt    = rom_q;
          w_if_pc_plus4_nxt = w_pc_plus4;
          w_if_valid_nxt    = 1'b1;
        end
        if (w_out_of_range && !w_redirect) begin
          w_state_nxt = ST_FAULT;
          w_fault_nxt = 1'b1;
        end
      end
      ST_FAULT: begin
        w_if_instr_nxt    = '0;
        w_if_pc_plus4_nxt = '0;
        w_if_valid_nxt    = 1'b0;
        w_fault_nxt       = 1'b1;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_pc          <= RESET_PC;
      r_if_instr    <= '0;
      r_if_pc_plus4 <= '0;
      r_if_valid    <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_if_instr    <= w_if_instr_nxt;
      r_if_pc_plus4 <= w_if_pc_plus4_nxt;
      r_if_valid    <= w_if_valid_nxt;
      r_fault       <= w_fault_nxt;
    end
  end

  assign pc             = r_pc;
  assign if_id_instr    = r_if_instr;
  assign if_id_pc_plus4 = r_if_pc_plus4;
  assign if_id_valid    = r_if_valid;
  assign fetch_fault    = r_fault;

endmodule
